// File: rtl/cs161_mc_datapath.sv
// Multi-cycle MIPS-subset datapath: PC, IR, register file, ALU and a 7-state FSM with
// req/ready memory handshakes. Define CS161_MC_PERF_CNT_EN to add cycle/retire counters.
module cs161_mc_datapath #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              halt,
   output logic [ADDR_W-1:0] prog_count,
   output logic [5:0]        instr_opcode,
   output logic              write_reg_en,
   output logic [4:0]        write_reg_addr,
   output logic [DATA_W-1:0] write_reg_data,
   output logic [2:0]        fsm_state
`ifdef CS161_MC_PERF_CNT_EN
   ,
   output logic [DATA_W-1:0] cycle_count,
   output logic [DATA_W-1:0] instr_retired
`endif
);

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
   logic [DATA_W-1:0] regs_q [32];

   logic [5:0]        op, funct;
   logic [4:0]        rs, rt, rd;
   logic [DATA_W-1:0] imm_sext, alu_res, rf_a, rf_b;
   logic [ADDR_W-1:0] br_off, jmp_tgt;
   logic              legal;
   logic              unused_shamt;

   assign op           = ir_q[31:26];
   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign funct        = ir_q[5:0];
   assign unused_shamt = ^ir_q[10:6];
   assign imm_sext     = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
   assign br_off       = {{(ADDR_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};
   assign rf_a         = (rs == 5'd0) ? '0 : regs_q[rs];
   assign rf_b         = (rt == 5'd0) ? '0 : regs_q[rt];

   // Jump keeps the upper PC bits above bit 27 (works for any ADDR_W >= 28).
   always_comb begin
      jmp_tgt       = pc_q;
      jmp_tgt[27:0] = {ir_q[25:0], 2'b00};
   end

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT);
         OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = a_q + imm_sext;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_ADD:  alu_res = a_q + b_q;
            FN_SUB:  alu_res = a_q - b_q;
            FN_AND:  alu_res = a_q & b_q;
            FN_OR:   alu_res = a_q | b_q;
            FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      write_reg_en = 1'b0;
      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = rf_a;
            b_d     = rf_b;
            state_d = legal ? S_EXEC : S_HALT;
         end
         S_EXEC: begin
            alu_d = alu_res;
            case (op)
               OP_RTYPE, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:      state_d = S_MEM;
               OP_BEQ: begin
                  // pc_q already points past the branch
                  if (a_q == b_q) pc_d = pc_q + br_off;
                  state_d = S_FETCH;
               end
               OP_J: begin
                  pc_d    = jmp_tgt;
                  state_d = S_FETCH;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_SW);
            if (dmem_ready) begin
               if (op == OP_SW) begin
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            write_reg_en = 1'b1;
            state_d      = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   assign write_reg_addr = (op == OP_RTYPE) ? rd : rt;
   assign write_reg_data = (op == OP_LW) ? mdr_q : alu_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (write_reg_en && (write_reg_addr != 5'd0)) begin
         regs_q[write_reg_addr] <= write_reg_data;
      end
   end

   generate
      if (ADDR_W <= DATA_W) begin : g_addr_trunc
         assign dmem_addr = alu_q[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign dmem_addr = {{(ADDR_W-DATA_W){1'b0}}, alu_q};
      end
   endgenerate

   assign imem_addr    = pc_q;
   assign dmem_wdata   = b_q;
   assign prog_count   = pc_q;
   assign instr_opcode = ir_q[31:26];
   assign halt         = (state_q == S_HALT);
   assign fsm_state    = state_q;

`ifdef CS161_MC_PERF_CNT_EN
   logic              retire;
   logic [DATA_W-1:0] cyc_q, ret_q;

   assign retire = (state_q == S_WB) ||
                   ((state_q == S_MEM) && dmem_ready && (op == OP_SW)) ||
                   ((state_q == S_EXEC) && ((op == OP_BEQ) || (op == OP_J)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if ((state_q != S_RST) && (state_q != S_HALT)) cyc_q <= cyc_q + 1'b1;
         if (retire) ret_q <= ret_q + 1'b1;
      end
   end

   assign cycle_count   = cyc_q;
   assign instr_retired = ret_q;
`endif

endmodule
